subpel_window_feeder: RTL and testbench



---
 rtl/subpel_pkg.sv | 19 +
 rtl/subpel_window_feeder_if.sv | 25 ++
 rtl/subpel_out_reg.sv | 45 ++++
 rtl/subpel_window_feeder.sv | 137 +++++++++++++
 tb/tb_subpel_window_feeder.sv | 377 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/subpel_pkg.sv
// Shared types and constants for the sub-pel window feeder and the FIR stages it feeds.
package subpel_pkg;

    localparam int PIX_W = 8;
    localparam int TAPS  = 8;
    localparam int WIN_W = PIX_W * TAPS;

    typedef enum logic [1:0] {FILL, STREAM, FLUSH} state_t;

    typedef logic [PIX_W-1:0]            pix_t;
    typedef logic [7:0]                  frac_t;
    typedef logic [TAPS-1:0][PIX_W-1:0]  win_t;

    // Oldest tap drops out of slot 0; the new pixel becomes tap 7.
    function automatic win_t shift_in(input win_t w, input pix_t p);
        return {p, w[TAPS-1:1]};
    endfunction

endpackage

// File: rtl/subpel_window_feeder_if.sv
// Pixel-in / window-out handshake bundle of the sub-pel window feeder.
interface subpel_window_feeder_if;
    import subpel_pkg::*;

    pix_t              in_pixel;
    frac_t             in_frac;
    logic              in_valid;
    logic              in_ready;
    logic [WIN_W-1:0]  out_window;
    frac_t             out_frac;
    logic              out_last;
    logic              out_valid;
    logic              out_ready;

    modport slave (
        input  in_pixel, in_frac, in_valid, out_ready,
        output in_ready, out_window, out_frac, out_last, out_valid
    );

    modport master (
        output in_pixel, in_frac, in_valid, out_ready,
        input  in_ready, out_window, out_frac, out_last, out_valid
    );

endinterface

// File: rtl/subpel_out_reg.sv
// Output register for window/phase/last with a valid/ready hold: contents only move when advance is high.
module subpel_out_reg
    import subpel_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              i_advance,
    input  logic              i_load,
    input  win_t              i_window,
    input  frac_t             i_frac,
    input  logic              i_last,
    output logic              o_valid,
    output logic [WIN_W-1:0]  o_window,
    output frac_t             o_frac,
    output logic              o_last
);

    logic              r_valid;
    logic [WIN_W-1:0]  r_window;
    frac_t             r_frac;
    logic              r_last;

    // Valid follows the load request each advancing cycle; data is only replaced on a real load.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid  <= 1'b0;
            r_window <= '0;
            r_frac   <= '0;
            r_last   <= 1'b0;
        end else if (i_advance) begin
            r_valid <= i_load;
            if (i_load) begin
                r_window <= i_window;
                r_frac   <= i_frac;
                r_last   <= i_last;
            end
        end
    end

    assign o_valid  = r_valid;
    assign o_window = r_window;
    assign o_frac   = r_frac;
    assign o_last   = r_last;

endmodule

// File: rtl/subpel_window_feeder.sv
// Turns a raster pixel row into one 8-tap window per column with edge padding at both ends.
// Build option SUBPEL_WINDOW_ZERO_PAD_EN: pad with zeros instead of replicating the edge pixels.
module subpel_window_feeder
    import subpel_pkg::*;
#(
    parameter int ROW_WIDTH = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    subpel_window_feeder_if.slave bus
);

    localparam int COL_W = $clog2(ROW_WIDTH);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(ROW_WIDTH - 1);
    localparam logic [COL_W-1:0] FILL_END = COL_W'(3);

    generate
        if (ROW_WIDTH < 5) begin : g_badRowWidth
            $error("subpel_window_feeder: ROW_WIDTH must be at least 5");
        end
    endgenerate

    state_t            r_state, w_stateNext;
    logic [COL_W-1:0]  r_col, w_colNext;
    logic [1:0]        r_fcnt, w_fcntNext;
    win_t              r_win, w_winNext;
    frac_t             r_frac, w_fracNext;

    logic  w_advance;
    logic  w_accept;
    logic  w_load;
    logic  w_last;
    logic  w_outValid;
    win_t  w_firstWin;
    pix_t  w_padPix;

    assign w_advance    = !w_outValid || bus.out_ready;
    assign bus.in_ready = w_advance && (r_state != FLUSH);
    assign w_accept     = bus.in_valid && bus.in_ready;

`ifdef SUBPEL_WINDOW_ZERO_PAD_EN
    assign w_firstWin = {bus.in_pixel, {((TAPS - 1) * PIX_W){1'b0}}};
    assign w_padPix   = '0;
`else
    assign w_firstWin = {TAPS{bus.in_pixel}};
    assign w_padPix   = r_win[TAPS-1];
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= FILL;
            r_col   <= '0;
            r_fcnt  <= '0;
            r_win   <= '0;
            r_frac  <= '0;
        end else begin
            r_state <= w_stateNext;
            r_col   <= w_colNext;
            r_fcnt  <= w_fcntNext;
            r_win   <= w_winNext;
            r_frac  <= w_fracNext;
        end
    end

    // Column 0 seeds the left padding, columns 1..3 prime the window, STREAM emits x = col-4,
    // and FLUSH pushes four pad taps to emit the last four columns of the row.
    always_comb begin
        w_stateNext = r_state;
        w_colNext   = r_col;
        w_fcntNext  = r_fcnt;
        w_winNext   = r_win;
        w_fracNext  = r_frac;
        w_load      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            FILL: begin
                if (w_accept) begin
                    if (r_col == '0) begin
                        w_winNext  = w_firstWin;
                        w_fracNext = bus.in_frac;
                        w_colNext  = COL_W'(1);
                    end else begin
                        w_winNext = shift_in(r_win, bus.in_pixel);
                        w_colNext = r_col + COL_W'(1);
                        if (r_col == FILL_END) begin
                            w_stateNext = STREAM;
                        end
                    end
                end
            end
            STREAM: begin
                if (w_accept) begin
                    w_winNext = shift_in(r_win, bus.in_pixel);
                    w_load    = 1'b1;
                    w_colNext = r_col + COL_W'(1);
                    if (r_col == LAST_COL) begin
                        w_stateNext = FLUSH;
                        w_fcntNext  = '0;
                    end
                end
            end
            FLUSH: begin
                if (w_advance) begin
                    w_winNext  = shift_in(r_win, w_padPix);
                    w_load     = 1'b1;
                    w_last     = (r_fcnt == 2'd3);
                    w_fcntNext = r_fcnt + 2'd1;
                    if (r_fcnt == 2'd3) begin
                        w_stateNext = FILL;
                        w_colNext   = '0;
                    end
                end
            end
            default: begin
                w_stateNext = FILL;
                w_colNext   = '0;
            end
        endcase
    end

    subpel_out_reg u_outReg (
        .clock     (clock),
        .reset     (reset),
        .i_advance (w_advance),
        .i_load    (w_load),
        .i_window  (w_winNext),
        .i_frac    (r_frac),
        .i_last    (w_last),
        .o_valid   (w_outValid),
        .o_window  (bus.out_window),
        .o_frac    (bus.out_frac),
        .o_last    (bus.out_last)
    );

    assign bus.out_valid = w_outValid;

endmodule

// File: tb/tb_subpel_window_feeder.sv
// Self-checking bench for subpel_window_feeder; expected windows come from a tap-position model of each row.
module tb_subpel_window_feeder;
    import subpel_pkg::*;

    localparam int ROW = 8;

    typedef logic [7:0] row_t [ROW];
    typedef struct packed {
        logic [63:0] win;
        logic [7:0]  frac;
        logic        last;
    } out_t;

    logic clock = 1'b0;
    logic reset;

    subpel_window_feeder_if bus ();

    subpel_window_feeder #(.ROW_WIDTH(ROW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int   total = 0;
    int   bad = 0;
    int   cycle = 0;
    int   readyMode = 0;
    int   phase = 0;
    int   gapPct = 0;
    int   firstValidCycle = -1;
    out_t gotQ[$];
    out_t expQ[$];
    int   acceptCycle[$];
    int   waitQ[$];

`ifdef SUBPEL_WINDOW_ZERO_PAD_EN
    localparam logic [63:0] SPEC_X0 = 64'h32281E140A000000;
    localparam logic [63:0] SPEC_X7 = 64'h0000000050463C32;
`else
    localparam logic [63:0] SPEC_X0 = 64'h32281E140A0A0A0A;
    localparam logic [63:0] SPEC_X7 = 64'h5050505050463C32;
`endif

    initial forever begin
        @(posedge clock);
        cycle = cycle + 1;
    end

    // Records every output transfer, sampled half a cycle before the edge that completes it.
    initial forever begin
        @(negedge clock);
        if (bus.out_valid === 1'b1 && firstValidCycle < 0) firstValidCycle = cycle;
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1)
            gotQ.push_back({bus.out_window, bus.out_frac, bus.out_last});
    end

    // Downstream back-pressure: always ready, a fixed 1,0,0,1 pattern, or random.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            case (readyMode)
                1: begin
                    bus.out_ready = (phase == 0 || phase == 3);
                    phase = (phase + 1) % 4;
                end
                2:       bus.out_ready = ($urandom_range(0, 3) != 0);
                default: bus.out_ready = 1'b1;
            endcase
        end
    end

    task automatic clear_logs();
        gotQ.delete();
        expQ.delete();
        acceptCycle.delete();
        waitQ.delete();
        firstValidCycle = -1;
    endtask

    // Reference: tap k of window x is the pixel at x-3+k, padded past either row end.
    task automatic build_expected(input row_t r, input logic [7:0] f);
        for (int x = 0; x < ROW; x++) begin
            logic [63:0] win;
            win = '0;
            for (int k = 0; k < 8; k++) begin
                int pos;
                logic [7:0] v;
                pos = x - 3 + k;
`ifdef SUBPEL_WINDOW_ZERO_PAD_EN
                if (pos < 0 || pos >= ROW) v = 8'h00;
                else v = r[pos];
`else
                if (pos < 0) v = r[0];
                else if (pos >= ROW) v = r[ROW-1];
                else v = r[pos];
`endif
                win[8*k +: 8] = v;
            end
            expQ.push_back({win, f, (x == ROW - 1)});
        end
    endtask

    task automatic applyStimulus(input logic [7:0] p, input logic [7:0] f, output int waits);
        waits = 0;
        bus.in_pixel = p;
        bus.in_frac  = f;
        bus.in_valid = 1'b1;
        do begin
            @(negedge clock);
            if (bus.in_ready !== 1'b1) waits++;
        end while (bus.in_ready !== 1'b1 && waits < 200);
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL accept_timeout pixel=%0d in_ready=%b required=1", p, bus.in_ready);
        end else begin
            acceptCycle.push_back(cycle);
        end
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Non-first pixels carry a random phase select, which the block must ignore.
    task automatic send_row(input row_t r, input logic [7:0] f);
        int w;
        for (int i = 0; i < ROW; i++) begin
            if (gapPct > 0 && $urandom_range(0, 99) < gapPct) begin
                @(posedge clock);
                #1;
            end
            applyStimulus(r[i], (i == 0) ? f : 8'($urandom), w);
            waitQ.push_back(w);
        end
    endtask

    task automatic wait_outputs(input int n);
        int c;
        c = 0;
        while (gotQ.size() < n && c < 600) begin
            @(negedge clock);
            c++;
        end
        repeat (8) @(negedge clock);
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_pixel = 8'h00;
        bus.in_frac  = 8'h00;
        @(posedge clock);
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b required=0", bus.out_valid); end
        total++; if (bus.out_window !== 64'h0) begin bad++; $display("[TB] FAIL reset_window got=%h required=0", bus.out_window); end
        total++; if (bus.out_frac !== 8'h00) begin bad++; $display("[TB] FAIL reset_frac got=%h required=0", bus.out_frac); end
        total++; if (bus.out_last !== 1'b0) begin bad++; $display("[TB] FAIL reset_last got=%b required=0", bus.out_last); end
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic test_basic_row();
        row_t r;
        readyMode = 0;
        gapPct = 0;
        clear_logs();
        for (int i = 0; i < ROW; i++) r[i] = 8'((i + 1) * 10);
        build_expected(r, 8'h01);
        send_row(r, 8'h01);
        wait_outputs(ROW);
        total++;
        if (gotQ.size() != expQ.size()) begin
            bad++; $display("[TB] FAIL basic_count got=%0d required=%0d", gotQ.size(), expQ.size());
        end
        foreach (expQ[i]) begin
            total++;
            if (i >= gotQ.size() || gotQ[i] !== expQ[i]) begin
                bad++;
                $display("[TB] FAIL basic_win[%0d] got=%h/%h/%b required=%h/%h/%b", i,
                         gotQ[i].win, gotQ[i].frac, gotQ[i].last, expQ[i].win, expQ[i].frac, expQ[i].last);
            end
        end
        total++;
        if (acceptCycle.size() < 5 || firstValidCycle != acceptCycle[4] + 1) begin
            bad++; $display("[TB] FAIL basic_latency first_valid=%0d accept5=%0d required_delta=1",
                            firstValidCycle, (acceptCycle.size() >= 5) ? acceptCycle[4] : -1);
        end
        if (gotQ.size() >= ROW) begin
            total++;
            if (gotQ[0].win !== SPEC_X0 || gotQ[0].frac !== 8'h01) begin
                bad++; $display("[TB] FAIL basic_x0 got=%h/%h required=%h/01", gotQ[0].win, gotQ[0].frac, SPEC_X0);
            end
            total++;
            if (gotQ[ROW-1].win !== SPEC_X7 || gotQ[ROW-1].last !== 1'b1 || gotQ[ROW-1].frac !== 8'h01) begin
                bad++; $display("[TB] FAIL basic_x7 got=%h/%h/%b required=%h/01/1",
                                gotQ[ROW-1].win, gotQ[ROW-1].frac, gotQ[ROW-1].last, SPEC_X7);
            end
        end
    endtask

    task automatic test_stall();
        row_t r;
        int stalls;
        int c;
        logic prevStall;
        logic [63:0] prevWin;
        stalls = 0;
        c = 0;
        prevStall = 1'b0;
        prevWin = '0;
        clear_logs();
        for (int i = 0; i < ROW; i++) r[i] = 8'((i + 1) * 10);
        build_expected(r, 8'h01);
        phase = 0;
        readyMode = 1;
        fork
            send_row(r, 8'h01);
            begin
                while (gotQ.size() < ROW && c < 400) begin
                    @(negedge clock);
                    c++;
                    if (prevStall) begin
                        total++;
                        if (bus.out_window !== prevWin) begin
                            bad++; $display("[TB] FAIL stall_hold got=%h required=%h", bus.out_window, prevWin);
                        end
                    end
                    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b0) begin
                        stalls++;
                        total++;
                        if (bus.in_ready !== 1'b0) begin
                            bad++; $display("[TB] FAIL stall_in_ready got=%b required=0", bus.in_ready);
                        end
                    end
                    prevStall = (bus.out_valid === 1'b1 && bus.out_ready === 1'b0);
                    prevWin = bus.out_window;
                end
            end
        join
        wait_outputs(ROW);
        readyMode = 0;
        total++;
        if (stalls == 0) begin bad++; $display("[TB] FAIL stall_seen got=0 required>0"); end
        total++;
        if (gotQ.size() != expQ.size()) begin
            bad++; $display("[TB] FAIL stall_count got=%0d required=%0d", gotQ.size(), expQ.size());
        end
        foreach (expQ[i]) begin
            total++;
            if (i >= gotQ.size() || gotQ[i] !== expQ[i]) begin
                bad++;
                $display("[TB] FAIL stall_win[%0d] got=%h/%h/%b required=%h/%h/%b", i,
                         gotQ[i].win, gotQ[i].frac, gotQ[i].last, expQ[i].win, expQ[i].frac, expQ[i].last);
            end
        end
    endtask

    task automatic test_back_to_back();
        row_t ra;
        row_t rb;
        readyMode = 0;
        gapPct = 0;
        clear_logs();
        for (int i = 0; i < ROW; i++) begin
            ra[i] = 8'((i + 1) * 10);
            rb[i] = 8'($urandom);
        end
        build_expected(ra, 8'h01);
        build_expected(rb, 8'h03);
        send_row(ra, 8'h01);
        send_row(rb, 8'h03);
        wait_outputs(2 * ROW);
        total++;
        if (waitQ.size() < ROW + 1 || waitQ[ROW] != 4) begin
            bad++; $display("[TB] FAIL b2b_flush_wait got=%0d required=4", (waitQ.size() > ROW) ? waitQ[ROW] : -1);
        end
        total++;
        if (gotQ.size() != expQ.size()) begin
            bad++; $display("[TB] FAIL b2b_count got=%0d required=%0d", gotQ.size(), expQ.size());
        end
        foreach (expQ[i]) begin
            total++;
            if (i >= gotQ.size() || gotQ[i] !== expQ[i]) begin
                bad++;
                $display("[TB] FAIL b2b_win[%0d] got=%h/%h/%b required=%h/%h/%b", i,
                         gotQ[i].win, gotQ[i].frac, gotQ[i].last, expQ[i].win, expQ[i].frac, expQ[i].last);
            end
        end
    endtask

    task automatic test_reset_mid_row();
        row_t r;
        int w;
        readyMode = 0;
        gapPct = 0;
        clear_logs();
        for (int i = 0; i < ROW; i++) r[i] = 8'((i + 1) * 10);
        for (int i = 0; i < 6; i++) applyStimulus(r[i], (i == 0) ? 8'h01 : 8'($urandom), w);
        #1;
        reset = 1'b1;
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL midreset_valid got=%b required=0", bus.out_valid); end
        total++; if (bus.out_window !== 64'h0) begin bad++; $display("[TB] FAIL midreset_window got=%h required=0", bus.out_window); end
        total++; if (bus.out_frac !== 8'h00) begin bad++; $display("[TB] FAIL midreset_frac got=%h required=0", bus.out_frac); end
        #2;
        reset = 1'b0;
        @(posedge clock);
        #1;
        clear_logs();
        build_expected(r, 8'h01);
        send_row(r, 8'h01);
        wait_outputs(ROW);
        total++;
        if (gotQ.size() != expQ.size()) begin
            bad++; $display("[TB] FAIL midreset_count got=%0d required=%0d", gotQ.size(), expQ.size());
        end
        foreach (expQ[i]) begin
            total++;
            if (i >= gotQ.size() || gotQ[i] !== expQ[i]) begin
                bad++;
                $display("[TB] FAIL midreset_win[%0d] got=%h/%h/%b required=%h/%h/%b", i,
                         gotQ[i].win, gotQ[i].frac, gotQ[i].last, expQ[i].win, expQ[i].frac, expQ[i].last);
            end
        end
    endtask

    task automatic test_random_rows();
        row_t r;
        logic [7:0] f;
        readyMode = 2;
        gapPct = 30;
        clear_logs();
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < ROW; i++) r[i] = 8'($urandom);
            f = 8'($urandom);
            build_expected(r, f);
            send_row(r, f);
        end
        wait_outputs(3 * ROW);
        readyMode = 0;
        gapPct = 0;
        total++;
        if (gotQ.size() != expQ.size()) begin
            bad++; $display("[TB] FAIL random_count got=%0d required=%0d", gotQ.size(), expQ.size());
        end
        foreach (expQ[i]) begin
            total++;
            if (i >= gotQ.size() || gotQ[i] !== expQ[i]) begin
                bad++;
                $display("[TB] FAIL random_win[%0d] got=%h/%h/%b required=%h/%h/%b", i,
                         gotQ[i].win, gotQ[i].frac, gotQ[i].last, expQ[i].win, expQ[i].frac, expQ[i].last);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_row();
        test_stall();
        test_back_to_back();
        test_reset_mid_row();
        test_random_rows();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
